insn_fetch_stage: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word-aligned requests to instruction memory over a variable-latency req/ack handshake.
- Captures returned instructions into a single-entry IF/ID register that drives the decoder's insn input.
- Honours downstream stall and branch redirect/flush (from the BEQ resolution path).

---
 rtl/insn_fetch_stage_pkg.sv | 15 +
 rtl/insn_fetch_stage_if.sv | 28 ++
 rtl/insn_fetch_stage_pc_unit.sv | 40 ++++
 rtl/insn_fetch_stage.sv | 87 ++++++++
 tb/tb_insn_fetch_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/insn_fetch_stage_pkg.sv
// Shared fetch-stage types: address width, instruction size, PC step and FSM state codes.
package insn_fetch_stage_pkg;

    localparam int INSN_ADDR_WIDTH = 32;
    localparam int INSN_WIDTH      = 32;
    localparam int INSN_BYTES      = 4;
    localparam int PC_INC          = INSN_BYTES;

    typedef logic [INSN_WIDTH-1:0] insn_t;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

endpackage

// File: rtl/insn_fetch_stage_if.sv
// Fetch-stage bus: decoder stall/redirect inputs, imem req/ack handshake, IF/ID outputs.
interface insn_fetch_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    import insn_fetch_stage_pkg::*;

    logic                  stall;
    logic                  brTaken;
    logic [ADDR_WIDTH-1:0] brTarget;
    logic                  imemReq;
    logic [ADDR_WIDTH-1:0] imemAddr;
    logic                  imemAck;
    insn_t                 imemData;
    insn_t                 insn;
    logic [ADDR_WIDTH-1:0] insnPC;
    logic                  insnValid;

    modport master (
        input  stall, brTaken, brTarget, imemAck, imemData,
        output imemReq, imemAddr, insn, insnPC, insnValid
    );

    modport slave (
        output stall, brTaken, brTarget, imemAck, imemData,
        input  imemReq, imemAddr, insn, insnPC, insnValid
    );

endinterface

// File: rtl/insn_fetch_stage_pc_unit.sv
// PC register: reset value, +4 step on enable, word-aligned redirect taking priority.
// Latency: new PC visible one edge after en/redirect.
module insn_fetch_stage_pc_unit
    import insn_fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = INSN_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_INC);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSN_BYTES - 1);

    logic [ADDR_WIDTH-1:0] pc_nxt;

    always_comb begin
        pc_nxt = pc;
        if (redirect) begin
            pc_nxt = target & ~ALIGN_MASK;
        end else if (en) begin
            // wraps modulo 2^ADDR_WIDTH
            pc_nxt = pc + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/insn_fetch_stage.sv
// Fetch stage: issues word-aligned imem requests and registers returned words into IF/ID.
// Latency: one edge from imemAck to insn; redirect flushes and discards any in-flight word.
module insn_fetch_stage
    import insn_fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = INSN_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    insn_fetch_stage_if.master     bus
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSN_BYTES - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    insn_t                 insn_q;
    logic [ADDR_WIDTH-1:0] insn_pc_q;
    logic                  insn_valid_q;

    logic slot_free;
    logic req;
    logic outstanding;
    logic capture;

    // While a request waits for its ack, insn_valid_q is necessarily 0, so the
    // slot stays free and req cannot drop before the ack arrives.
    assign slot_free   = !insn_valid_q || !bus.stall;
    assign req         = (state == S_REQ) && slot_free && !rst;
    assign outstanding = req || (state == S_DROP);
    assign capture     = req && bus.imemAck && !bus.brTaken;

    always_comb begin
        state_nxt = state;
        if (bus.brTaken) begin
            state_nxt = (outstanding && !bus.imemAck) ? S_DROP : S_REQ;
        end else begin
            case (state)
                S_REQ:   if (!req) state_nxt = S_HOLD;
                S_HOLD:  if (!bus.stall) state_nxt = S_REQ;
                S_DROP:  if (bus.imemAck) state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            insn_valid_q <= 1'b0;
            insn_q       <= '0;
            insn_pc_q    <= '0;
        end else begin
            state <= state_nxt;
            if (bus.brTaken) begin
                insn_valid_q <= 1'b0;
            end else if (capture) begin
                insn_valid_q <= 1'b1;
                insn_q       <= bus.imemData;
                insn_pc_q    <= pc;
            end else if (!bus.stall) begin
                insn_valid_q <= 1'b0;
            end
        end
    end

    insn_fetch_stage_pc_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .en       (capture),
        .redirect (bus.brTaken),
        .target   (bus.brTarget),
        .pc       (pc)
    );

    assign bus.imemReq   = req;
    assign bus.imemAddr  = pc & ~ALIGN_MASK;
    assign bus.insn      = insn_q;
    assign bus.insnPC    = insn_pc_q;
    assign bus.insnValid = insn_valid_q;

endmodule

// File: tb/tb_insn_fetch_stage.sv
// Directed bench for insn_fetch_stage with a variable-latency instruction memory model.
module tb_insn_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    insn_fetch_stage_if #(.ADDR_WIDTH(32)) bus();

    insn_fetch_stage #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory: lat=1 acks in the request cycle; lat=N acks in the Nth cycle.
    int          lat;
    logic        busy;
    int          wcnt;
    logic [31:0] laddr;
    int          cyc;

    always_comb begin
        cyc          = busy ? wcnt : 0;
        bus.imemAck  = (busy || bus.imemReq) && (cyc >= lat - 1);
        bus.imemData = img(busy ? laddr : bus.imemAddr);
    end

    always @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            wcnt <= 0;
        end else if (bus.imemAck) begin
            busy <= 1'b0;
            wcnt <= 0;
        end else if (busy || bus.imemReq) begin
            if (!busy) laddr <= bus.imemAddr;
            busy <= 1'b1;
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        int          lat;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
        logic        ezero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic s, input logic b, input logic [31:0] t,
                               input int l, input logic rq, input logic [31:0] ad,
                               input logic vl, input logic [31:0] pc, input logic z);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.lat = l;
        x.ereq = rq; x.eaddr = ad; x.evld = vl; x.epc = pc; x.ezero = z;
        return x;
    endfunction

    initial begin
        int n;
        logic [31:0] exp_pc;

        //            rst stl br  tgt            lat  req addr           vld pc             zero
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'h0,          0, 32'h0,          1));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'h4,          1, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'h8,          1, 32'h4,          0));
        // stall with slot full: hold insnPC=8, no requests
        vecs.push_back(v(0, 1, 0, 32'h0,         1,   0, 32'hC,          1, 32'h8,          0));
        vecs.push_back(v(0, 1, 0, 32'h0,         1,   0, 32'hC,          1, 32'h8,          0));
        vecs.push_back(v(0, 1, 0, 32'h0,         1,   0, 32'hC,          1, 32'h8,          0));
        vecs.push_back(v(0, 1, 0, 32'h0,         1,   0, 32'hC,          1, 32'h8,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   0, 32'hC,          1, 32'h8,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'hC,          0, 32'h0,          0));
        // 3-cycle latency at 0x10
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h10,         1, 32'hC,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h10,         0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h10,         0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'h14,         1, 32'h10,         0));
        // redirect to 0x41 with request outstanding
        vecs.push_back(v(0, 0, 1, 32'h41,        2,   1, 32'h18,         1, 32'h14,         0));
        vecs.push_back(v(0, 0, 0, 32'h0,         2,   0, 32'h40,         0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         2,   1, 32'h40,         0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         2,   1, 32'h40,         0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         2,   1, 32'h44,         1, 32'h40,         0));
        // redirect coincident with ack and stall
        vecs.push_back(v(0, 1, 1, 32'h80,        2,   1, 32'h44,         0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'h80,         0, 32'h0,          0));
        // redirect with same-cycle ack, then wraparound
        vecs.push_back(v(0, 0, 1, 32'hFFFF_FFFC, 1,   1, 32'h84,         1, 32'h80,         0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC,  0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h0,          1, 32'hFFFF_FFFC,  0));
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h0,          0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h0,          0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h4,          1, 32'h0,          0));
        // reset in the middle of a wait at 0x4
        vecs.push_back(v(0, 0, 0, 32'h0,         3,   1, 32'h4,          0, 32'h0,          0));
        vecs.push_back(v(1, 0, 0, 32'h0,         3,   0, 32'h4,          0, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'h0,          0, 32'h0,          1));
        // reset while holding a live insn
        vecs.push_back(v(1, 0, 0, 32'h0,         1,   0, 32'h4,          1, 32'h0,          0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1,   1, 32'h0,          0, 32'h0,          1));

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.brTaken = 1'b0;
        bus.brTarget = 32'h0;
        lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req",   {31'b0, bus.imemReq},   32'h0);
        chk("reset_valid", {31'b0, bus.insnValid}, 32'h0);
        chk("reset_insn",  bus.insn,               32'h0);
        chk("reset_pc",    bus.insnPC,             32'h0);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            bus.stall    = vecs[i].stall;
            bus.brTaken  = vecs[i].br;
            bus.brTarget = vecs[i].tgt;
            lat          = vecs[i].lat;
            #1;
            chk($sformatf("v%0d_req", i),   {31'b0, bus.imemReq},   {31'b0, vecs[i].ereq});
            chk($sformatf("v%0d_addr", i),  bus.imemAddr,           vecs[i].eaddr);
            chk($sformatf("v%0d_valid", i), {31'b0, bus.insnValid}, {31'b0, vecs[i].evld});
            if (vecs[i].evld) begin
                chk($sformatf("v%0d_pc", i),   bus.insnPC, vecs[i].epc);
                chk($sformatf("v%0d_insn", i), bus.insn,   img(vecs[i].epc));
            end else if (vecs[i].ezero) begin
                chk($sformatf("v%0d_pc0", i),   bus.insnPC, vecs[i].epc);
                chk($sformatf("v%0d_insn0", i), bus.insn,   32'h0);
            end
            @(negedge clk);
        end

        // Streaming at 2-cycle latency: four consecutive words, no duplicate or skip.
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.brTaken = 1'b0;
        lat = 2;
        n = 0;
        exp_pc = 32'h0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            #1;
            if (bus.insnValid) begin
                chk($sformatf("seq%0d_pc", n),   bus.insnPC, exp_pc);
                chk($sformatf("seq%0d_insn", n), bus.insn,   img(exp_pc));
                exp_pc = exp_pc + 32'h4;
                n++;
            end
            @(negedge clk);
        end
        chk("seq_count", n, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
